// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker: FSM encoding,
// default sweep parameters and the expected tables of each lab function option.
package tt_sweep_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_N_IN       = 3;
    localparam int DEF_SETTLE_CYC = 4;

    // Expected tables, bit i = f(vector i) with x=bit0, y=bit1, z=bit2.
    // (x+y)(x'+z)
    localparam logic [7:0] EXP_TT_2TERM = 8'hE4;
    // (x+y)(x'+z)(y+z): the consensus term adds nothing, so same table
    localparam logic [7:0] EXP_TT_3TERM = 8'hE4;
    // (x+y)(y+z): a common wrong answer, differs only at vector 3
    localparam logic [7:0] EXP_TT_WRONG = 8'hEC;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Settle-window counter: cleared by load, counts while enabled, and flags
// the last drive cycle of a vector (count == SETTLE_CYC-1).
module tt_settle_counter
    import tt_sweep_checker_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic term
);

    localparam int CW = cnt_width(SETTLE_CYC);

    logic [CW-1:0] cnt;

    // Clear on reset or load, otherwise advance while the sweep is driving.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == CW'(SETTLE_CYC - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Clocked truth-table sweep: drives every input vector to a combinational
// function block, samples its output after a settle window, and compares the
// captured table against an expected table.
module tt_sweep_checker
    import tt_sweep_checker_pkg::*;
#(
    parameter int                 N_IN       = DEF_N_IN,
    parameter int                 SETTLE_CYC = DEF_SETTLE_CYC,
    parameter logic [2**N_IN-1:0] EXP_TABLE  = EXP_TT_2TERM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   tt_captured,
    output logic [N_IN:0]        err_cnt,
    output logic                 first_err_valid,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int            NV       = 2**N_IN;
    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(NV - 1);

    state_t        state;
    logic [N_IN:0] idx;
    logic [N_IN:0] idx_next;
    logic          cnt_load;
    logic          cnt_en;
    logic          cnt_term;
    logic          mismatch;
    logic [N_IN:0] err_next;

    // The settle count restarts on every new vector: at sweep accept and on
    // leaving SAMPLE for the next vector.
    assign cnt_load = ((state == ST_IDLE) && start) || (state == ST_SAMPLE);
    assign cnt_en   = (state == ST_DRIVE);

    tt_settle_counter #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .term (cnt_term)
    );

    assign idx_next = idx + 1'b1;
    assign mismatch = (dut_in != EXP_TABLE[idx[N_IN-1:0]]);
    assign err_next = err_cnt + {{N_IN{1'b0}}, mismatch};

    // Sweep FSM with registered outputs. pass is taken from err_next so the
    // last vector's sample is included in the verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            idx             <= '0;
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            tt_captured     <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tt_captured     <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        pass            <= 1'b0;
                        idx             <= '0;
                        vec_out         <= '0;
                        busy            <= 1'b1;
                        state           <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_term) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    tt_captured[idx[N_IN-1:0]] <= dut_in;
                    if (mismatch) begin
                        err_cnt <= err_next;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= idx[N_IN-1:0];
                        end
                    end
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= ST_DONE;
                    end else begin
                        idx     <= idx_next;
                        vec_out <= idx_next[N_IN-1:0];
                        state   <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (SETTLE_CYC=4 and 1) each driven
// by a behavioural lab function block; results are predicted from the
// function's truth table computed directly from the boolean expressions.
module tb_tt_sweep_checker;
    import tt_sweep_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, start1;
    logic [2:0] vec, vec1;
    logic       din, din1;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [7:0] tt, tt1;
    logic [3:0] err, err1;
    logic       fev, fev1;
    logic [2:0] fei, fei1;

    int         fsel, fsel1;
    logic [7:0] rnd_tt, rnd_tt1;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs and function blocks ----------------
    tt_sweep_checker #(.N_IN(3), .SETTLE_CYC(4), .EXP_TABLE(EXP_TT_2TERM)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec), .dut_in(din),
        .busy(busy), .done(done), .pass(pass), .tt_captured(tt), .err_cnt(err),
        .first_err_valid(fev), .first_err_idx(fei)
    );

    tt_sweep_checker #(.N_IN(3), .SETTLE_CYC(1), .EXP_TABLE(EXP_TT_2TERM)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .dut_in(din1),
        .busy(busy1), .done(done1), .pass(pass1), .tt_captured(tt1), .err_cnt(err1),
        .first_err_valid(fev1), .first_err_idx(fei1)
    );

    // Lab function options: 0 correct 2-term, 1 full 3-term, 2 wrong, else random table.
    function automatic logic plant(input int sel, input logic [7:0] rt, input logic [2:0] v);
        logic x, y, z;
        x = v[0];
        y = v[1];
        z = v[2];
        case (sel)
            0:       return (x | y) & (!x | z);
            1:       return (x | y) & (!x | z) & (y | z);
            2:       return (x | y) & (y | z);
            default: return rt[v];
        endcase
    endfunction

    assign din  = plant(fsel, rnd_tt, vec);
    assign din1 = plant(fsel1, rnd_tt1, vec1);

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_table(input int sel, input logic [7:0] rt);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = plant(sel, rt, 3'(i));
        return t;
    endfunction

    function automatic int model_errs(input logic [7:0] t);
        return $countones(t ^ 8'hE4);
    endfunction

    function automatic int model_first(input logic [7:0] t);
        logic [7:0] d;
        int f;
        d = t ^ 8'hE4;
        f = 0;
        for (int i = 7; i >= 0; i--) if (d[i]) f = i;
        return f;
    endfunction

    // ---------------- driver ----------------
    // Pulse start on one instance, then count cycles after the accept edge
    // until done is seen; also counts vec_out steps that miss the schedule.
    task automatic run_sweep(input bit which, output int cyc, output int vbad);
        int per, last;
        per  = which ? 2 : 5;
        last = per * 8;
        vbad = 0;
        @(negedge clk);
        if (which) start1 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start1 = 1'b0;
        cyc = 1;
        while (((which ? done1 : done) !== 1'b1) && cyc < 200) begin
            if (cyc <= last && (which ? vec1 : vec) !== 3'((cyc - 1) / per)) vbad++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        fsel = 0; fsel1 = 0; rnd_tt = 8'h00; rnd_tt1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, pass, tt, err, fev, fei, vec} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {busy, done, pass, tt, err, fev, fei, vec});
        end
        total++;
        if ({busy1, done1, pass1, tt1, err1, fev1, fei1, vec1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs1: got %h want 0", {busy1, done1, pass1, tt1, err1, fev1, fei1, vec1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_function(input int sel, input int exp_cyc);
        int cyc, vbad, e_err, e_first;
        logic [7:0] e;
        fsel = sel;
        exp_q.push_back(model_table(sel, rnd_tt));
        run_sweep(1'b0, cyc, vbad);
        e = exp_q.pop_front();
        e_err = model_errs(e);
        e_first = (e_err != 0) ? model_first(e) : 0;
        total++;
        if (cyc != exp_cyc) begin bad++; $display("FAIL sweep_latency sel=%0d: got %0d want %0d", sel, cyc, exp_cyc); end
        total++;
        if (vbad != 0) begin bad++; $display("FAIL vec_schedule sel=%0d: got %0d off-schedule want 0", sel, vbad); end
        total++;
        if (tt !== e) begin bad++; $display("FAIL tt_captured sel=%0d: got %h want %h", sel, tt, e); end
        total++;
        if (err !== 4'(e_err)) begin bad++; $display("FAIL err_cnt sel=%0d: got %0d want %0d", sel, err, e_err); end
        total++;
        if (fev !== (e_err != 0) || fei !== 3'(e_first)) begin
            bad++;
            $display("FAIL first_err sel=%0d: got %b/%0d want %b/%0d", sel, fev, fei, (e_err != 0), e_first);
        end
        total++;
        if (pass !== (e_err == 0) || busy !== 1'b1) begin
            bad++;
            $display("FAIL pass_busy_at_done sel=%0d: got %b%b want %b1", sel, pass, busy, (e_err == 0));
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || tt !== e || pass !== (e_err == 0) || vec !== 3'd7) begin
            bad++;
            $display("FAIL hold_after_done sel=%0d: got d%b b%b tt%h p%b v%0d want d0 b0 tt%h p%b v7",
                     sel, done, busy, tt, pass, vec, e, (e_err == 0));
        end
    endtask

    task automatic test_settle1(input int sel);
        int cyc, vbad, e_err;
        logic [7:0] e;
        fsel1 = sel;
        exp_q.push_back(model_table(sel, rnd_tt1));
        run_sweep(1'b1, cyc, vbad);
        e = exp_q.pop_front();
        e_err = model_errs(e);
        total++;
        if (cyc != 17) begin bad++; $display("FAIL settle1_latency sel=%0d: got %0d want 17", sel, cyc); end
        total++;
        if (vbad != 0) begin bad++; $display("FAIL settle1_vec sel=%0d: got %0d off-schedule want 0", sel, vbad); end
        total++;
        if (tt1 !== e || err1 !== 4'(e_err) || pass1 !== (e_err == 0)) begin
            bad++;
            $display("FAIL settle1_result sel=%0d: got %h/%0d/%b want %h/%0d/%b", sel, tt1, err1, pass1, e, e_err, (e_err == 0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int k, dones;
        fsel = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 1;
        while (k < 17) begin @(posedge clk); #1; k++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({busy, done, pass, tt, err, fev, fei, vec} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h want 0", {busy, done, pass, tt, err, fev, fei, vec});
        end
        dones = 0;
        repeat (60) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        total++;
        if (dones != 0) begin bad++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", dones); end
        test_function(0, 41);
    endtask

    task automatic test_restart_ignored();
        int k, first_done, dones;
        fsel = 2;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        first_done = 0;
        dones = 0;
        for (k = 1; k <= 70; k++) begin
            if (done === 1'b1) begin dones++; if (first_done == 0) first_done = k; end
            start = (k == 5 || k == 30);
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++;
        if (first_done != 41 || dones != 1) begin
            bad++;
            $display("FAIL restart_ignored: got done@%0d x%0d want done@41 x1", first_done, dones);
        end
        total++;
        if (err !== 4'd1 || fei !== 3'd3 || tt !== 8'hEC) begin
            bad++;
            $display("FAIL restart_result: got err%0d idx%0d tt%h want err1 idx3 ttEC", err, fei, tt);
        end
    endtask

    task automatic test_back_to_back();
        int k, n, d0, d1;
        fsel = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        k = 1; n = 0; d0 = 0; d1 = 0;
        while (n < 2 && k < 200) begin
            if (done === 1'b1) begin
                if (n == 0) d0 = k; else d1 = k;
                n++;
            end
            if (n < 2) begin @(posedge clk); #1; k++; end
        end
        start = 1'b0;
        total++;
        if (d0 != 41 || d1 != 83) begin
            bad++;
            $display("FAIL start_held_retrigger: got %0d,%0d want 41,83", d0, d1);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || pass !== 1'b1) begin
            bad++;
            $display("FAIL start_held_idle: got busy%b pass%b want busy0 pass1", busy, pass);
        end
    endtask

    initial begin
        test_reset();
        test_function(0, 41);
        test_function(1, 41);
        test_function(2, 41);
        test_reset_mid();
        test_restart_ignored();
        test_back_to_back();
        test_settle1(0);
        test_settle1(2);
        repeat (6) begin
            rnd_tt = 8'($urandom_range(0, 255));
            test_function(3, 41);
            rnd_tt1 = 8'($urandom_range(0, 255));
            test_settle1(3);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
